// File: rtl/sccb_target.sv
// sccb_target: SCCB responder with a 256x8 register file, write strobe and open-drain read data.
// Build macro SCCB_ACK_EN: drive I2C-style ACKs in the 9th-bit slots instead of releasing sda.
`timescale 1ns/1ps
module sccb_target #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef SCCB_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUBADDR, S_SA_ACK,
    S_WDATA, S_WD_ACK, S_RDATA, S_RD_NA, S_IGNORE
  } state_t;

  state_t        state_reg, state_next;
  logic [NS-1:0] scl_sync, sda_sync;
  logic          scl_d, sda_d;
  logic          scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shreg_reg, shreg_next, ptr_reg, ptr_next, rx_byte;
  logic          sda_oe_next, busy_next, wr_strobe_next;
  logic [7:0]    wr_addr_next, wr_data_next;
  logic [7:0]    mem [256];

  // Sync flops idle high so releasing reset on a quiet bus creates no events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NS-2:0], scl_in};
      sda_sync <= {sda_sync[NS-2:0], sda_in};
      scl_d    <= scl_sync[NS-1];
      sda_d    <= sda_sync[NS-1];
    end
  end

  assign scl       = scl_sync[NS-1];
  assign sda       = sda_sync[NS-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;
  assign rx_byte   = {shreg_reg[6:0], sda};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start_det) begin
      state_next = S_ID;
    end else if (stop_det) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_ID:
          if (scl_rise && bit_cnt_reg == 3'd7)
            state_next = (rx_byte[7:1] != DEV_ID[7:1]) ? S_IGNORE : S_ID_ACK;
        S_ID_ACK:  if (scl_fall && bit_cnt_reg == 3'd1) state_next = shreg_reg[0] ? S_RDATA : S_SUBADDR;
        S_SUBADDR: if (scl_rise && bit_cnt_reg == 3'd7) state_next = S_SA_ACK;
        S_SA_ACK:  if (scl_fall && bit_cnt_reg == 3'd1) state_next = S_WDATA;
        S_WDATA:   if (scl_rise && bit_cnt_reg == 3'd7) state_next = S_WD_ACK;
        S_WD_ACK:  if (scl_fall && bit_cnt_reg == 3'd1) state_next = S_IGNORE;
        S_RDATA:   if (scl_rise && bit_cnt_reg == 3'd7) state_next = S_RD_NA;
        S_RD_NA:   if (scl_rise) state_next = S_IGNORE;
        default:   state_next = state_reg;
      endcase
    end
  end

  // In ACK slots bit_cnt marks whether the 9th clock has risen; the following fall ends the slot
  always_comb begin
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    ptr_next       = ptr_reg;
    sda_oe_next    = sda_oe;
    busy_next      = busy;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr;
    wr_data_next   = wr_data;
    if (start_det) begin
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b1;
    end else if (stop_det) begin
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        S_ID, S_SUBADDR, S_WDATA: begin
          if (scl_rise) begin
            shreg_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7 && state_reg == S_SUBADDR) ptr_next = rx_byte;
            if (bit_cnt_reg == 3'd7 && state_reg == S_WDATA) begin
              wr_strobe_next = 1'b1;
              wr_addr_next   = ptr_reg;
              wr_data_next   = rx_byte;
            end
          end
        end
        S_ID_ACK, S_SA_ACK, S_WD_ACK: begin
          if (scl_rise) begin
            bit_cnt_next = 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 3'd1) begin
              bit_cnt_next = '0;
              sda_oe_next  = 1'b0;
              if (state_reg == S_ID_ACK && shreg_reg[0]) begin
                shreg_next  = mem[ptr_reg];
                sda_oe_next = ~mem[ptr_reg][7];
              end
            end else begin
              sda_oe_next = ACK_DRIVE;
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end else if (scl_fall) begin
            shreg_next  = {shreg_reg[6:0], shreg_reg[7]};
            sda_oe_next = ~shreg_reg[6];
          end
        end
        default: if (scl_fall) sda_oe_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      ptr_reg     <= '0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_data     <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      ptr_reg     <= ptr_next;
      sda_oe      <= sda_oe_next;
      busy        <= busy_next;
      wr_strobe   <= wr_strobe_next;
      wr_addr     <= wr_addr_next;
      wr_data     <= wr_data_next;
      if (wr_strobe_next) mem[ptr_reg] <= rx_byte;
      rd_data     <= mem[rd_addr];
    end
  end
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bit-banged SCCB master driving sccb_target; table vectors, corner sequences
// and random transactions checked against a transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_sccb_target;
  localparam int Q = 6;
`ifdef SCCB_ACK_EN
  localparam logic ACK_EXP = 1'b1;
`else
  localparam logic ACK_EXP = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_oe, wr_strobe, busy, sda_line;
  logic [7:0] wr_addr, wr_data, rd_addr = 8'h00, rd_data;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  sccb_target #(.DEV_ID(8'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  logic [15:0] strobe_q[$];
  int          width_err = 0;
  logic        strobe_d = 1'b0;
  always @(negedge clk) begin
    if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
    if (wr_strobe && strobe_d) width_err <= width_err + 1;
    strobe_d <= wr_strobe;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: register array plus persistent sub-address pointer
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr;
  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_ptr = 8'h00;
  endtask
  // kind: 0 = 3-phase write, 1 = 2-phase write, 2 = 2-phase read
  task automatic model_txn(input int kind, input logic [7:0] id, sub, data,
                           output logic match, output int nwr, output logic [7:0] rd);
    match = (id[7:1] == 7'h21);
    nwr   = 0;
    rd    = 8'h00;
    if (match) begin
      if (kind == 2) rd = m_mem[m_ptr];
      else m_ptr = sub;
      if (kind == 0) begin
        m_mem[sub] = data;
        nwr = 1;
      end
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask
  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask
  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q(); wait_q();
  endtask
  task automatic bit_cycle(input logic b, output logic pre, output logic hi);
    sda_m = b; wait_q();
    pre = sda_oe;
    scl_m = 1'b1; wait_q();
    hi = sda_oe; wait_q();
    scl_m = 1'b0; wait_q();
  endtask
  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic pre, hi;
    logic [7:0] oe_bits;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(b[i], pre, hi);
      oe_bits[i] = pre | hi;
    end
    chk({tag, " data-bit sda_oe"}, oe_bits, 8'h00);
    bit_cycle(1'b1, pre, hi);
    chk({tag, " ack-slot sda_oe"}, {pre, hi}, {exp_ack, exp_ack});
  endtask
  task automatic recv_byte(input logic [7:0] exp_oe, input string tag);
    logic pre, hi;
    logic [7:0] got, moved;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, pre, hi);
      got[i]   = pre;
      moved[i] = pre ^ hi;
    end
    chk({tag, " read sda_oe pattern"}, got, exp_oe);
    chk({tag, " sda_oe stable while scl high"}, moved, 8'h00);
    bit_cycle(1'b1, pre, hi);
    chk({tag, " NA-slot sda_oe"}, {pre, hi}, 2'b00);
  endtask
  task automatic peek(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    @(negedge clk) rd_addr = addr;
    @(negedge clk);
    chk({tag, " rd_data peek"}, rd_data, exp);
  endtask
  task automatic run_txn(input int kind, input logic [7:0] id, sub, data, input logic match,
                         input int nwr, input logic [7:0] waddr, wdata, rd, input string tag);
    int   q0;
    logic ack;
    q0  = strobe_q.size();
    ack = match ? ACK_EXP : 1'b0;
    bus_start();
    chk({tag, " busy after START"}, busy, 1'b1);
    send_byte(id, ack, {tag, " id"});
    if (kind == 2) begin
      recv_byte(match ? ~rd : 8'h00, tag);
    end else begin
      send_byte(sub, ack, {tag, " sub"});
      if (kind == 0) send_byte(data, ack, {tag, " data"});
    end
    bus_stop();
    chk({tag, " busy after STOP"}, busy, 1'b0);
    chk({tag, " wr_strobe count"}, strobe_q.size() - q0, nwr);
    if (nwr == 1 && strobe_q.size() > q0)
      chk({tag, " wr_addr/wr_data"}, strobe_q[q0], {waddr, wdata});
  endtask

  typedef struct {
    int         kind;
    logic [7:0] id, sub, data;
    logic       match;
    int         nwr;
    logic [7:0] waddr, wdata, rd, paddr, pval;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic       m, pre, hi;
    int         nw, kind, q0;
    logic [7:0] rdv, id, sub, data, pa;
    tbl[0]  = '{0, 8'h42, 8'h12, 8'h80, 1'b1, 1, 8'h12, 8'h80, 8'h00, 8'h12, 8'h80};
    tbl[1]  = '{0, 8'h42, 8'h3A, 8'h5C, 1'b1, 1, 8'h3A, 8'h5C, 8'h00, 8'h3A, 8'h5C};
    tbl[2]  = '{1, 8'h42, 8'h3A, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h3A, 8'h5C};
    tbl[3]  = '{2, 8'h43, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h5C, 8'h12, 8'h80};
    tbl[4]  = '{0, 8'h60, 8'h12, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h80};
    tbl[5]  = '{2, 8'h43, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h5C, 8'hFF, 8'h00};
    tbl[6]  = '{0, 8'h42, 8'h00, 8'hA5, 1'b1, 1, 8'h00, 8'hA5, 8'h00, 8'h00, 8'hA5};
    tbl[7]  = '{2, 8'h43, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'hA5, 8'h3A, 8'h5C};
    tbl[8]  = '{2, 8'h61, 8'h00, 8'h00, 1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h80};
    tbl[9]  = '{1, 8'h42, 8'h12, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h80};
    tbl[10] = '{2, 8'h43, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h80, 8'h00, 8'hA5};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset outputs {sda_oe,wr_strobe,busy}", {sda_oe, wr_strobe, busy}, 3'b000);
    chk("reset {wr_addr,wr_data,rd_data}", {wr_addr, wr_data, rd_data}, 24'h0);
    rst = 1'b0;
    wait_q();

    for (int i = 0; i < 11; i++) begin
      model_txn(tbl[i].kind, tbl[i].id, tbl[i].sub, tbl[i].data, m, nw, rdv);
      run_txn(tbl[i].kind, tbl[i].id, tbl[i].sub, tbl[i].data, tbl[i].match, tbl[i].nwr,
              tbl[i].waddr, tbl[i].wdata, tbl[i].rd, $sformatf("vec%0d", i));
      peek(tbl[i].paddr, tbl[i].pval, $sformatf("vec%0d", i));
    end

    // STOP after four bits of the data byte: no write, back to idle
    q0 = strobe_q.size();
    bus_start();
    send_byte(8'h42, ACK_EXP, "stop4 id");
    send_byte(8'h20, ACK_EXP, "stop4 sub");
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, pre, hi);
    bus_stop();
    chk("stop4 busy after STOP", busy, 1'b0);
    chk("stop4 wr_strobe count", strobe_q.size() - q0, 0);
    model_txn(1, 8'h42, 8'h20, 8'h00, m, nw, rdv);
    peek(8'h20, m_mem[8'h20], "stop4");
    model_txn(2, 8'h43, 8'h00, 8'h00, m, nw, rdv);
    run_txn(2, 8'h43, 8'h00, 8'h00, m, nw, 8'h00, 8'h00, rdv, "stop4 readback");

    // Repeated START after three bits of the sub-address
    bus_start();
    send_byte(8'h42, ACK_EXP, "rstart id");
    for (int i = 0; i < 3; i++) bit_cycle(i[0], pre, hi);
    model_txn(0, 8'h42, 8'h21, 8'h77, m, nw, rdv);
    run_txn(0, 8'h42, 8'h21, 8'h77, m, nw, 8'h21, 8'h77, rdv, "rstart");
    peek(8'h21, 8'h77, "rstart");

    // Reset asserted while driving a read data bit low
    model_txn(0, 8'h42, 8'h30, 8'h11, m, nw, rdv);
    run_txn(0, 8'h42, 8'h30, 8'h11, m, nw, 8'h30, 8'h11, rdv, "prerst");
    peek(8'h30, 8'h11, "prerst");
    bus_start();
    send_byte(8'h43, ACK_EXP, "rstread id");
    sda_m = 1'b1;
    wait_q();
    chk("rstread sda_oe before reset", sda_oe, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstread sda_oe async drop", sda_oe, 1'b0);
    chk("rstread outputs {wr_strobe,busy}", {wr_strobe, busy}, 2'b00);
    chk("rstread {wr_addr,wr_data,rd_data}", {wr_addr, wr_data, rd_data}, 24'h0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_q();
    peek(8'h30, m_mem[8'h30], "postrst");

    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) begin
        id = 8'($urandom);
        if (id[7:1] == 7'h21) id[7:1] = 7'h30;
      end else begin
        id = 8'h42;
      end
      id[0] = (kind == 2);
      sub  = 8'h40 | 8'($urandom_range(0, 7));
      data = 8'($urandom);
      model_txn(kind, id, sub, data, m, nw, rdv);
      run_txn(kind, id, sub, data, m, nw, sub, data, rdv, $sformatf("rand%0d", n));
      pa = 8'h40 | 8'($urandom_range(0, 7));
      peek(pa, m_mem[pa], $sformatf("rand%0d", n));
    end

    @(negedge clk);
    chk("wr_strobe pulse width errors", width_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
